// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies external reset and optional PLL lock, then releases NUM_CH resets in order.
// Latency: rst[i] falls SYNC_STAGES+POR_CYCLES+i*STAGE_GAP edges after rst_n rises (lock-filtered if USE_LOCK).
// Backpressure: none; soft_rst_req is a level request honoured on the next edge.
//
// Ports:
//   clk           platform clock, all state on rising edge
//   rst_n         async active-low reset, deassertion synchronised
//   pll_lock      async PLL lock indicator (ignored when USE_LOCK=0)
//   soft_rst_req  level request for a full re-sequence (clk domain)
//   rst           active-high channel resets, bit 0 released first
//   ready         high once every channel is released
module reset_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int POR_CYCLES  = 3,
    parameter int STAGE_GAP   = 4,
    parameter int USE_LOCK    = 0,
    parameter int LOCK_FILTER = 16,
    parameter int SOFT_HOLD   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] rst,
    output logic              ready
);

    localparam int MAX_A   = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
    localparam int MAX_B   = (LOCK_FILTER > SOFT_HOLD) ? LOCK_FILTER : SOFT_HOLD;
    localparam int CNT_TOP = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] POR_TERM  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SOFT_TERM = CNT_W'(SOFT_HOLD - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN,
        SOFT
    } state_t;

    localparam state_t ST_INIT = (USE_LOCK != 0) ? WAIT_LOCK : HOLD;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [NUM_CH-1:0]      rst_q, rst_d;
    logic                   ready_q, ready_d;
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;

    logic             run_ok;
    logic             lock_ok;
    logic [CNT_W-1:0] cnt_inc;

    assign run_ok  = rst_sync_q[SYNC_STAGES-1];
    // Without lock gating the lock is treated as permanently good.
    assign lock_ok = (USE_LOCK == 0) || lock_sync_q[SYNC_STAGES-1];
    // Saturating increment: the counter never wraps back to a terminal value.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ch_q        <= '0;
            rst_q       <= '1;
            ready_q     <= 1'b0;
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            rst_q       <= rst_d;
            ready_q     <= ready_d;
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        // Nothing moves until the synchronised reset release arrives.
        if (run_ok) begin
            if (state_q == WAIT_LOCK) begin
                // Soft requests are ignored here: all channels are already held.
                rst_d   = '1;
                ready_d = 1'b0;
                if (!lock_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_TERM) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (!lock_ok) begin
                // Lock loss outranks a simultaneous soft request.
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                ch_d    = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end else if (soft_rst_req) begin
                // Also keeps SOFT parked with a cleared counter while held high.
                state_d = SOFT;
                cnt_d   = '0;
                ch_d    = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == POR_TERM) begin
                            rst_d[0] = 1'b0;
                            cnt_d    = '0;
                            ch_d     = CH_W'(1);
                            if (NUM_CH == 1) begin
                                state_d = RUN;
                                ready_d = 1'b1;
                            end else begin
                                state_d = RELEASE;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == GAP_TERM) begin
                            rst_d[ch_q] = 1'b0;
                            cnt_d       = '0;
                            ch_d        = ch_q + CH_W'(1);
                            if (ch_q == LAST_CH) begin
                                state_d = RUN;
                                ready_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    SOFT: begin
                        // Request has dropped; lock is known good at this point.
                        if (cnt_q == SOFT_TERM) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        // RUN: outputs hold until a reassert event.
                    end
                endcase
            end
        end
    end

    assign rst   = rst_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n_a, rst_n_b;
    logic       lock_a, lock_b;
    logic       soft_a, soft_b;
    logic [2:0] rst_a, rst_b;
    logic       ready_a, ready_b;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;

    typedef struct {
        int         cyc;
        bit         dut;
        logic [2:0] rst;
        logic       rdy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    reset_sequencer #(.USE_LOCK(0)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n_a),
        .pll_lock     (lock_a),
        .soft_rst_req (soft_a),
        .rst          (rst_a),
        .ready        (ready_a)
    );

    reset_sequencer #(.USE_LOCK(1)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n_b),
        .pll_lock     (lock_b),
        .soft_rst_req (soft_b),
        .rst          (rst_b),
        .ready        (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: {rst,ready} observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push(int c, bit d, logic [2:0] r, logic y, string t);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.rst = r;
        e.rdy = y;
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic goto(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard drain: compare every expectation due at this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag,
                    sb[i].dut ? {rst_b, ready_b} : {rst_a, ready_a},
                    {sb[i].rst, sb[i].rdy});
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c3, d, n;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        lock_a  = 1'b0;
        lock_b  = 1'b0;
        soft_a  = 1'b0;
        soft_b  = 1'b0;
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;

        goto(2);
        chk("reset_a", {rst_a, ready_a}, 4'b1110);
        chk("reset_b", {rst_b, ready_b}, 4'b1110);

        // Basic release ordering, no lock gating
        c = cyc;
        rst_n_a = 1'b1;
        push(c + 1,  0, 3'b111, 1'b0, "t1_hold_e1");
        push(c + 4,  0, 3'b111, 1'b0, "t1_hold_e4");
        push(c + 5,  0, 3'b110, 1'b0, "t1_rel0_e5");
        push(c + 8,  0, 3'b110, 1'b0, "t1_gap_e8");
        push(c + 9,  0, 3'b100, 1'b0, "t1_rel1_e9");
        push(c + 12, 0, 3'b100, 1'b0, "t1_gap_e12");
        push(c + 13, 0, 3'b000, 1'b1, "t1_rel2_ready_e13");
        push(c + 20, 0, 3'b000, 1'b1, "t1_run_stable");
        goto(c + 22);

        // Soft request from RUN, then again mid-RELEASE
        c = cyc;
        soft_a = 1'b1;
        push(c + 1, 0, 3'b111, 1'b0, "t4_soft_from_run");
        goto(c + 5);
        soft_a = 1'b0;
        push(c + 15, 0, 3'b111, 1'b0, "t4_soft_hold");
        push(c + 16, 0, 3'b110, 1'b0, "t4_rel0_after_soft");
        goto(c + 17);
        soft_a = 1'b1;
        push(c + 18, 0, 3'b111, 1'b0, "t4_soft_mid_release");
        goto(c + 22);
        soft_a = 1'b0;
        push(c + 32, 0, 3'b111, 1'b0, "t4_mid_soft_hold");
        push(c + 33, 0, 3'b110, 1'b0, "t4_mid_rel0");
        push(c + 37, 0, 3'b100, 1'b0, "t4_mid_rel1");
        push(c + 41, 0, 3'b000, 1'b1, "t4_mid_ready");
        goto(c + 44);

        // Asynchronous reset assertion between clock edges
        rst_n_a = 1'b0;
        #2;
        chk("t5_async_from_run", {rst_a, ready_a}, 4'b1110);
        @(negedge clk);
        c = cyc;
        rst_n_a = 1'b1;
        push(c + 6, 0, 3'b110, 1'b0, "t5_pre_async");
        goto(c + 6);
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("t5_async_mid_release", {rst_a, ready_a}, 4'b1110);
        push(c + 9, 0, 3'b111, 1'b0, "t5_async_held");
        goto(c + 10);

        // Lock-gated instance: held while unlocked, filter restarts on a glitch
        c = cyc;
        rst_n_b = 1'b1;
        push(c + 6, 1, 3'b111, 1'b0, "t2_no_lock_held");
        goto(c + 8);
        c = cyc;
        lock_b = 1'b1;
        goto(c + 10);
        lock_b = 1'b0;
        goto(c + 11);
        lock_b = 1'b1;
        c3 = cyc;
        push(c + 22,  1, 3'b111, 1'b0, "t2_filter_restart");
        push(c3 + 20, 1, 3'b111, 1'b0, "t2_pre_rel0");
        push(c3 + 21, 1, 3'b110, 1'b0, "t2_rel0_after_filter");
        push(c3 + 29, 1, 3'b000, 1'b1, "t2_ready");
        goto(c3 + 31);

        // One-cycle lock drop from RUN
        d = cyc;
        lock_b = 1'b0;
        push(d + 2,  1, 3'b000, 1'b1, "t3_still_run");
        push(d + 3,  1, 3'b111, 1'b0, "t3_lock_loss_reassert");
        push(d + 21, 1, 3'b111, 1'b0, "t3_refilter");
        push(d + 22, 1, 3'b110, 1'b0, "t3_rel0_again");
        goto(d + 1);
        lock_b = 1'b1;
        goto(d + 24);

        // Lock loss and soft request on the same edge mid-RELEASE: lock wins
        n = cyc;
        lock_b = 1'b0;
        push(n + 2,  1, 3'b100, 1'b0, "t5_mid_release_b");
        push(n + 3,  1, 3'b111, 1'b0, "t5_both_reassert");
        push(n + 14, 1, 3'b111, 1'b0, "t5_lock_wins_not_soft");
        push(n + 21, 1, 3'b111, 1'b0, "t5_pre_rel0");
        push(n + 22, 1, 3'b110, 1'b0, "t5_rel0_after_filter");
        goto(n + 1);
        lock_b = 1'b1;
        goto(n + 2);
        soft_b = 1'b1;
        goto(n + 3);
        soft_b = 1'b0;
        goto(n + 26);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drained: pending observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
